// File: rtl/tlu_trigger_unit_pkg.sv
// tlu_trigger_unit_pkg: register map, mode/state encodings and data-word helpers
package tlu_trigger_unit_pkg;
  localparam logic [7:0] VERSION = 8'h01;
  localparam logic MARKER = 1'b1;
  localparam logic [3:0] REG_VERSION  = 4'd0;
  localparam logic [3:0] REG_MODE     = 4'd1;
  localparam logic [3:0] REG_TRIG_SEL = 4'd2;
  localparam logic [3:0] REG_VETO_SEL = 4'd3;
  localparam logic [3:0] REG_CNT0     = 4'd4;
  localparam logic [3:0] REG_CNT1     = 4'd5;
  localparam logic [3:0] REG_CNT2     = 4'd6;
  localparam logic [3:0] REG_CNT3     = 4'd7;
  localparam logic [3:0] REG_LOST     = 4'd8;
  localparam logic [3:0] REG_STATUS   = 4'd9;
  typedef enum logic [1:0] {MODE_OFF = 2'd0, MODE_EXT = 2'd1, MODE_TLU = 2'd2, MODE_OFF3 = 2'd3} mode_t;
  typedef enum logic [2:0] {ST_IDLE, ST_BUSY, ST_CLOCK, ST_DONE, ST_WAIT_LOW} state_t;
  function automatic logic [31:0] ext_word(input logic [30:0] c);
    return {MARKER, c};
  endfunction
  function automatic logic [31:0] tlu_word(input logic [14:0] id);
    return {MARKER, 16'b0, id};
  endfunction
endpackage

// File: rtl/tlu_trigger_unit_if.sv
// tlu_trigger_unit_if: basil bus control and show-ahead FIFO read port
interface tlu_trigger_unit_if #(parameter int ABUSWIDTH = 16);
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic BUS_RD;
  logic BUS_WR;
  logic FIFO_READ;
  logic FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  modport master (output BUS_ADD, BUS_RD, BUS_WR, FIFO_READ, input FIFO_EMPTY, FIFO_DATA);
  modport slave (input BUS_ADD, BUS_RD, BUS_WR, FIFO_READ, output FIFO_EMPTY, FIFO_DATA);
endinterface

// File: rtl/tlu_trigger_unit_fifo.sv
// tlu_trigger_fifo: 16x32 synchronous show-ahead FIFO that flags dropped pushes
module tlu_trigger_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        empty,
  output logic        full,
  output logic        drop
);
  logic [31:0] mem [16];
  logic [4:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == 5'b10000;
  assign do_rd = pop && !empty;
  // a pop frees the slot being written, so a push into a full FIFO still lands
  assign do_wr = push && (!full || do_rd);
  assign drop = push && !do_wr;
  assign dout = empty ? 32'h0 : mem[rd_ptr[3:0]];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[3:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {4'b0, do_wr};
      rd_ptr <= rd_ptr + {4'b0, do_rd};
    end
endmodule

// File: rtl/tlu_trigger_unit.sv
// tlu_trigger_unit: external/TLU trigger acceptance with register bus and trigger-word FIFO
module tlu_trigger_unit
  import tlu_trigger_unit_pkg::*;
#(
  parameter int ABUSWIDTH = 16,
  parameter logic [ABUSWIDTH-1:0] BASEADDR = '0,
  parameter logic [ABUSWIDTH-1:0] HIGHADDR = '0,
  parameter int DIVISOR = 16,
  parameter int TLU_TRIGGER_MAX_CLOCK_CYCLES = 16
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RST,
  tlu_trigger_unit_if.slave bus,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] TRIGGER,
  input  logic [7:0] TRIGGER_VETO,
  input  logic       TLU_TRIGGER,
  input  logic       TLU_RESET,
  output logic       TLU_BUSY,
  output logic       TLU_CLOCK
);
  localparam int CW = $clog2(DIVISOR);
  localparam int PW = $clog2(TLU_TRIGGER_MAX_CLOCK_CYCLES);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
  localparam logic [PW-1:0] LAST_P = PW'(TLU_TRIGGER_MAX_CLOCK_CYCLES - 1);
  localparam logic [ABUSWIDTH-1:0] SPAN = HIGHADDR - BASEADDR;
  logic [ABUSWIDTH-1:0] off;
  logic [3:0] idx;
  logic sel, wr_sel, soft_rst, rst_all;
  logic rd_en;
  logic [7:0] rd_data, rd_mux;
  mode_t mode;
  logic [7:0] trig_sel, veto_sel, lost;
  logic [31:0] trig_cnt;
  logic veto, trig_r, trig_r2, ext_acc, tlu_done;
  logic [1:0] tlu_trig_s, tlu_rst_s;
  logic tlu_trig, tlu_rst;
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pulse;
  logic [7:0] wait_cnt;
  logic [14:0] id;
  logic push;
  logic [31:0] push_data;
  logic fifo_full, drop;
  assign off = bus.BUS_ADD - BASEADDR;
  assign idx = off[3:0];
  assign sel = (off <= SPAN) && (off[ABUSWIDTH-1:4] == '0);
  assign wr_sel = bus.BUS_WR && sel;
  assign rst_all = BUS_RST || soft_rst;
  assign BUS_DATA = rd_en ? rd_data : 8'hzz;
  assign veto = |(TRIGGER_VETO & veto_sel);
  assign tlu_trig = tlu_trig_s[1];
  assign tlu_rst = tlu_rst_s[1];
  assign ext_acc = mode == MODE_EXT && trig_r && !trig_r2 && !veto;
  assign tlu_done = mode == MODE_TLU && state == ST_DONE;
  always_ff @(posedge BUS_CLK)
    soft_rst <= !BUS_RST && wr_sel && idx == REG_VERSION;
  always_comb begin
    rd_mux = 8'h00;
    case (idx)
      REG_VERSION:  rd_mux = VERSION;
      REG_MODE:     rd_mux = {6'b0, mode};
      REG_TRIG_SEL: rd_mux = trig_sel;
      REG_VETO_SEL: rd_mux = veto_sel;
      REG_CNT0, REG_CNT1, REG_CNT2, REG_CNT3: rd_mux = trig_cnt[{idx[1:0], 3'b0} +: 8];
      REG_LOST:     rd_mux = lost;
      REG_STATUS:   rd_mux = {6'b0, fifo_full, state != ST_IDLE};
      default:      rd_mux = 8'h00;
    endcase
  end
  always_ff @(posedge BUS_CLK)
    if (rst_all) begin
      rd_en <= 1'b0;
      rd_data <= 8'h00;
      mode <= MODE_OFF;
      trig_sel <= 8'h00;
      veto_sel <= 8'h00;
      lost <= 8'h00;
      trig_r <= 1'b0;
      trig_r2 <= 1'b0;
      tlu_trig_s <= 2'b00;
      tlu_rst_s <= 2'b00;
      push <= 1'b0;
      push_data <= 32'h0;
    end else begin
      rd_en <= bus.BUS_RD && sel;
      rd_data <= rd_mux;
      if (wr_sel && idx == REG_MODE) mode <= mode_t'(BUS_DATA[1:0]);
      if (wr_sel && idx == REG_TRIG_SEL) trig_sel <= BUS_DATA;
      if (wr_sel && idx == REG_VETO_SEL) veto_sel <= BUS_DATA;
      if (wr_sel && idx == REG_LOST) lost <= 8'h00;
      else if (drop && lost != 8'hff) lost <= lost + 8'd1;
      trig_r <= |(TRIGGER & trig_sel);
      trig_r2 <= trig_r;
      tlu_trig_s <= {tlu_trig_s[0], TLU_TRIGGER};
      tlu_rst_s <= {tlu_rst_s[0], TLU_RESET};
      push <= ext_acc || tlu_done;
      push_data <= ext_acc ? ext_word(trig_cnt[30:0]) : tlu_word(id);
    end
  always_ff @(posedge BUS_CLK)
    if (rst_all || tlu_rst) trig_cnt <= 32'h0;
    else if (wr_sel && idx[3:2] == 2'b01) trig_cnt[{idx[1:0], 3'b0} +: 8] <= BUS_DATA;
    else if (ext_acc || tlu_done) trig_cnt <= trig_cnt + 32'd1;
  // leaving TLU mode aborts any handshake in progress
  always_ff @(posedge BUS_CLK)
    if (rst_all || mode != MODE_TLU) begin
      state <= ST_IDLE;
      TLU_BUSY <= 1'b0;
      TLU_CLOCK <= 1'b0;
      cnt <= '0;
      pulse <= '0;
      wait_cnt <= 8'h00;
      id <= 15'h0;
    end else begin
      case (state)
        ST_IDLE: if (tlu_trig && !veto) begin
          state <= ST_BUSY;
          TLU_BUSY <= 1'b1;
          cnt <= '0;
          id <= 15'h0;
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF_M1) begin
            state <= ST_CLOCK;
            TLU_CLOCK <= 1'b1;
            cnt <= '0;
            pulse <= '0;
          end
        end
        ST_CLOCK: begin
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          TLU_CLOCK <= cnt == LAST || cnt < HALF_M1;
          if (cnt == HALF_M1 && pulse != LAST_P) id[pulse] <= tlu_trig;
          if (cnt == LAST) begin
            pulse <= pulse + 1'b1;
            if (pulse == LAST_P) begin
              state <= ST_DONE;
              TLU_CLOCK <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          TLU_BUSY <= 1'b0;
          wait_cnt <= 8'h00;
          state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (!tlu_trig || wait_cnt == 8'd254) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  tlu_trigger_fifo u_fifo (
    .clk  (BUS_CLK),
    .rst  (rst_all),
    .push (push),
    .din  (push_data),
    .pop  (bus.FIFO_READ),
    .dout (bus.FIFO_DATA),
    .empty(bus.FIFO_EMPTY),
    .full (fifo_full),
    .drop (drop)
  );
endmodule

// File: tb/tb_tlu_trigger_unit.sv
// tb_tlu_trigger_unit: directed self-checking bench for tlu_trigger_unit
module tb_tlu_trigger_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] trigger = 8'h00;
  logic [7:0] trigger_veto = 8'h00;
  logic tlu_trigger = 1'b0;
  logic tlu_reset = 1'b0;
  wire tlu_busy, tlu_clock;
  logic drv = 1'b0;
  logic [7:0] dout = 8'h00;
  wire [7:0] bus_data;
  logic [7:0] rd;
  int checks = 0;
  int errors = 0;
  int pulses, n;
  tlu_trigger_unit_if #(.ABUSWIDTH(16)) bus_if ();
  assign bus_data = drv ? dout : 8'hzz;
  always #5 clk = ~clk;
  tlu_trigger_unit #(.ABUSWIDTH(16), .BASEADDR(16'h0000), .HIGHADDR(16'h000F),
                     .DIVISOR(16), .TLU_TRIGGER_MAX_CLOCK_CYCLES(16)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .bus(bus_if.slave), .BUS_DATA(bus_data),
    .TRIGGER(trigger), .TRIGGER_VETO(trigger_veto), .TLU_TRIGGER(tlu_trigger),
    .TLU_RESET(tlu_reset), .TLU_BUSY(tlu_busy), .TLU_CLOCK(tlu_clock)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_if.BUS_ADD = a;
    dout = d;
    drv = 1'b1;
    bus_if.BUS_WR = 1'b1;
    tick(1);
    bus_if.BUS_WR = 1'b0;
    drv = 1'b0;
  endtask
  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    bus_if.BUS_ADD = a;
    bus_if.BUS_RD = 1'b1;
    tick(1);
    d = bus_data;
    bus_if.BUS_RD = 1'b0;
  endtask
  task automatic pulse_trig(input logic [7:0] t);
    trigger = t;
    tick(2);
    trigger = 8'h00;
    tick(4);
  endtask
  task automatic pop_check(input string tag, input logic [31:0] exp);
    chk(tag, bus_if.FIFO_DATA, exp);
    bus_if.FIFO_READ = 1'b1;
    tick(1);
    bus_if.FIFO_READ = 1'b0;
  endtask
  task automatic tlu_send(input logic [14:0] id);
    logic prev;
    tlu_trigger = 1'b1;
    n = 0;
    while (!tlu_busy && n < 20) begin
      tick(1);
      n++;
    end
    chk("tlu_busy_latency", n, 3);
    chk("tlu_clock_low_in_busy", tlu_clock, 1'b0);
    pulses = 0;
    prev = 1'b0;
    n = 0;
    while (tlu_busy && n < 600) begin
      if (tlu_clock && !prev) begin
        pulses++;
        if (pulses < 16) tlu_trigger = id[pulses-1];
        else tlu_trigger = 1'b0;
      end
      prev = tlu_clock;
      tick(1);
      n++;
    end
    tlu_trigger = 1'b0;
    chk("tlu_busy_drop", tlu_busy, 1'b0);
    chk("tlu_pulse_count", pulses, 16);
    tick(6);
    chk("tlu_clock_idle", tlu_clock, 1'b0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus_if.BUS_ADD = 16'h0;
    bus_if.BUS_RD = 1'b0;
    bus_if.BUS_WR = 1'b0;
    bus_if.FIFO_READ = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_empty", bus_if.FIFO_EMPTY, 1'b1);
    chk("rst_data", bus_if.FIFO_DATA, 32'h0);
    chk("rst_busy", tlu_busy, 1'b0);
    chk("rst_clock", tlu_clock, 1'b0);
    bus_read(16'd0, rd); chk("version", rd, 8'h01);
    bus_read(16'd9, rd); chk("rst_status", rd, 8'h00);
    bus_read(16'd4, rd); chk("rst_cnt", rd, 8'h00);
    bus_write(16'd1, 8'h01);
    bus_write(16'd2, 8'h02);
    bus_write(16'd3, 8'h00);
    bus_read(16'd1, rd); chk("mode_rb", rd, 8'h01);
    trigger = 8'h02;
    tick(2);
    chk("ext_lat2", bus_if.FIFO_EMPTY, 1'b1);
    tick(1);
    chk("ext_lat3", bus_if.FIFO_EMPTY, 1'b0);
    trigger = 8'h00;
    tick(3);
    pulse_trig(8'h02);
    pulse_trig(8'h01);
    pulse_trig(8'h02);
    pop_check("ext_w0", 32'h80000000);
    pop_check("ext_w1", 32'h80000001);
    pop_check("ext_w2", 32'h80000002);
    chk("ext_drained", bus_if.FIFO_EMPTY, 1'b1);
    bus_read(16'd4, rd); chk("ext_cnt", rd, 8'h03);
    bus_write(16'd3, 8'h02);
    trigger_veto = 8'h02;
    pulse_trig(8'h02);
    pulse_trig(8'h02);
    chk("veto_empty", bus_if.FIFO_EMPTY, 1'b1);
    bus_read(16'd4, rd); chk("veto_cnt", rd, 8'h03);
    trigger_veto = 8'h00;
    pulse_trig(8'h02);
    pop_check("veto_release", 32'h80000003);
    bus_write(16'd3, 8'h00);
    bus_write(16'd4, 8'h00);
    for (int i = 0; i < 20; i++) pulse_trig(8'h02);
    bus_read(16'd8, rd); chk("ovf_lost", rd, 8'h04);
    bus_read(16'd9, rd); chk("ovf_status", rd, 8'h02);
    bus_read(16'd4, rd); chk("ovf_cnt", rd, 8'h14);
    bus_write(16'd8, 8'h55);
    bus_read(16'd8, rd); chk("lost_clear", rd, 8'h00);
    for (int i = 0; i < 16; i++) pop_check("ovf_word", 32'h80000000 + i);
    chk("ovf_drained", bus_if.FIFO_EMPTY, 1'b1);
    bus_write(16'd1, 8'h02);
    tlu_send(15'h0000);
    tlu_send(15'h0001);
    tlu_send(15'h05A5);
    bus_read(16'd9, rd); chk("tlu_status_idle", rd, 8'h00);
    pop_check("tlu_w0", 32'h80000000);
    pop_check("tlu_w1", 32'h80000001);
    pop_check("tlu_w2", 32'h800005A5);
    bus_read(16'd4, rd); chk("tlu_cnt", rd, 8'h17);
    tlu_trigger = 1'b1;
    n = 0;
    while (!tlu_clock && n < 40) begin
      tick(1);
      n++;
    end
    chk("abort_clock_seen", tlu_clock, 1'b1);
    tick(20);
    bus_write(16'd1, 8'h00);
    chk("abort_busy_before", tlu_busy, 1'b1);
    tick(1);
    chk("abort_busy", tlu_busy, 1'b0);
    chk("abort_clock", tlu_clock, 1'b0);
    tlu_trigger = 1'b0;
    tick(4);
    bus_read(16'd9, rd); chk("abort_status", rd, 8'h00);
    chk("abort_no_word", bus_if.FIFO_EMPTY, 1'b1);
    tlu_reset = 1'b1;
    tick(3);
    tlu_reset = 1'b0;
    tick(2);
    bus_read(16'd4, rd); chk("tlu_reset_cnt", rd, 8'h00);
    bus_write(16'd1, 8'h01);
    bus_write(16'd0, 8'h00);
    tick(1);
    bus_read(16'd1, rd); chk("soft_rst_mode", rd, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
